// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and strobe encodings for the pipeline
// sequencing controller of the 5-stage RV32I core.
package pipe_ctrl_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_ctrl_state_t;

  // Strobe bundle; bit order matches the field order below (pc_en is MSB).
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_strobes_t;

  // Normal flow: everything advances, nothing is squashed.
  localparam pipe_strobes_t STROBES_IDLE     = 7'b11111_00;
  // Frozen or halted: nothing moves, nothing is cleared.
  localparam pipe_strobes_t STROBES_OFF      = 7'b00000_00;
  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX.
  localparam pipe_strobes_t STROBES_LOADUSE  = 7'b00111_01;
  // Redirect: fetch the new target, squash both wrong-path slots.
  localparam pipe_strobes_t STROBES_REDIRECT = 7'b11111_11;
  // Halt accepted: stop fetching, squash younger instructions.
  localparam pipe_strobes_t STROBES_HALT     = 7'b01111_11;
  // Draining: bubbles enter EX while MEM and WB retire older work.
  localparam pipe_strobes_t STROBES_DRAIN    = 7'b00111_01;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector. Flags an ID-stage
// instruction that reads the destination of a load still in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W = 5
) (
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic                 ex_memread,
  output logic                 lu
);

  logic rd_nonzero_s;
  logic rs_match_s;

  // x0 never carries a dependency, so a load targeting it cannot stall.
  always_comb begin
    rd_nonzero_s = (ex_rd != {RF_ADDR_W{1'b0}});
    rs_match_s   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    lu           = ex_memread && rd_nonzero_s && rs_match_s;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller. Produces PC / buffer-register
// enables and flushes, handles load-use stalls, redirects, data-memory
// freezes and halt draining.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall_cnt and
// flush_cnt performance counters (ports absent when undefined).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W    = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic                 ex_memread,
  input  logic                 ex_redirect,
  input  logic                 ex_halt,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  pipe_ctrl_state_t state_r;
  pipe_ctrl_state_t state_s;
  logic [CNT_W-1:0] drain_cnt_r;
  logic [CNT_W-1:0] drain_cnt_s;
  logic             halted_r;
  pipe_strobes_t    strb_s;
  logic             lu_s;
  logic             freeze_s;

  hazard_detect #(
    .RF_ADDR_W (RF_ADDR_W)
  ) u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .lu         (lu_s)
  );

  // An outstanding data access with no acknowledge freezes the whole pipe.
  always_comb begin
    freeze_s = mem_req && !mem_ack;
  end

  // Next-state and strobe decode; freeze dominates, then halt, redirect, lu.
  always_comb begin
    strb_s      = STROBES_IDLE;
    state_s     = state_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      // The acknowledge cycle of MEM_WAIT is an ordinary RUN cycle: the
      // instruction held in EX during the wait is evaluated there.
      RUN, MEM_WAIT: begin
        if (freeze_s) begin
          strb_s  = STROBES_OFF;
          state_s = MEM_WAIT;
        end else if (ex_halt) begin
          strb_s      = STROBES_HALT;
          state_s     = DRAIN;
          drain_cnt_s = DRAIN_LOAD;
        end else if (ex_redirect) begin
          strb_s  = STROBES_REDIRECT;
          state_s = RUN;
        end else if (lu_s) begin
          strb_s  = STROBES_LOADUSE;
          state_s = RUN;
        end else begin
          strb_s  = STROBES_IDLE;
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (freeze_s) begin
          strb_s = STROBES_OFF;
        end else begin
          strb_s = STROBES_DRAIN;
          if (drain_cnt_r == {CNT_W{1'b0}}) begin
            state_s = HALTED;
          end else begin
            drain_cnt_s = drain_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      HALTED: begin
        strb_s  = STROBES_OFF;
        state_s = HALTED;
      end
      default: begin
        strb_s  = STROBES_OFF;
        state_s = RUN;
      end
    endcase
  end

  // State, drain counter and halted flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RUN;
      drain_cnt_r <= {CNT_W{1'b0}};
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
      halted_r    <= (state_s == HALTED);
    end
  end

  assign pc_en      = strb_s.pc_en;
  assign ifid_en    = strb_s.ifid_en;
  assign idex_en    = strb_s.idex_en;
  assign exmem_en   = strb_s.exmem_en;
  assign memwb_en   = strb_s.memwb_en;
  assign ifid_flush = strb_s.ifid_flush;
  assign idex_flush = strb_s.idex_flush;
  assign halted     = halted_r;

`ifdef PIPE_CTRL_PERF_EN
  logic        redirect_acc_s;
  logic        stall_evt_s;
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Event qualifiers for the performance counters.
  always_comb begin
    redirect_acc_s = ((state_r == RUN) || (state_r == MEM_WAIT)) &&
                     !freeze_s && !ex_halt && ex_redirect;
    stall_evt_s    = !strb_s.pc_en && (state_r != HALTED);
  end

  // Saturating stall and flush counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_evt_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (redirect_acc_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench with a scoreboard queue for pipe_ctrl.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, ex_redirect, ex_halt, mem_req, mem_ack;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.RF_ADDR_W(5), .DRAIN_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_redirect (ex_redirect),
    .ex_halt     (ex_halt),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .halted      (halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Strobe vectors {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}.
  localparam logic [6:0] S_IDLE  = 7'b11111_00;
  localparam logic [6:0] S_OFF   = 7'b00000_00;
  localparam logic [6:0] S_LU    = 7'b00111_01;
  localparam logic [6:0] S_RDR   = 7'b11111_11;
  localparam logic [6:0] S_HALT  = 7'b01111_11;
  localparam logic [6:0] S_DRAIN = 7'b00111_01;

  typedef struct packed {
    logic [6:0]  strb;
    logic        hlt;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;
  logic [31:0] acc_stall = 32'd0;
  logic [31:0] acc_flush = 32'd0;

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s.%s: got %0h, expected %0h", nm, what, act, exp);
    end
  endtask

  // One cycle of stimulus; the expected response goes to the scoreboard.
  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mrd, input logic rdr,
                      input logic hlt, input logic req, input logic ack,
                      input logic [6:0] e_strb, input logic e_h, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_memread = mrd;
    ex_redirect = rdr; ex_halt = hlt; mem_req = req; mem_ack = ack;
    if (rst) begin
      acc_stall = 32'd0;
      acc_flush = 32'd0;
    end
    e.strb = e_strb; e.hlt = e_h; e.stall = acc_stall; e.flush = acc_flush;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (!rst) begin
      if (!e_strb[6] && !e_h) acc_stall = acc_stall + 32'd1;
      if (e_strb[6] && e_strb[1]) acc_flush = acc_flush + 32'd1;
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "strobes", {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                            ifid_flush, idex_flush}, {25'd0, e.strb});
        chk(nm, "halted", {31'd0, halted}, {31'd0, e.hlt});
`ifdef PIPE_CTRL_PERF_EN
        chk(nm, "stall_cnt", stall_cnt, e.stall);
        chk(nm, "flush_cnt", flush_cnt, e.flush);
`endif
      end
    end
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    ex_redirect = 1'b0; ex_halt = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    //    rst rs1   rs2   rd    mrd   rdr   hlt   req   ack   expect   h
    step(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "reset_idle");
    step(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "reset_idle2");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "run_idle");
    step(0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_LU,   1'b0, "lu_rs1");
    step(0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "lu_bubble");
    step(0, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_LU,   1'b0, "lu_rs2");
    step(0, 5'd3, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "lu_rs2_bubble");
    step(0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "lu_x0");
    step(0, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "lu_nomatch");
    step(0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_RDR,  1'b0, "redirect_lu");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "post_redirect");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, "ack_no_req");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_OFF,  1'b0, "memwait_1");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, S_OFF,  1'b0, "memwait_2_redirect");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_OFF,  1'b0, "memwait_3_halt");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_IDLE, 1'b0, "mem_ack");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "post_ack");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_HALT, 1'b0, "halt_redirect");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN,1'b0, "drain_1");
    step(0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_DRAIN,1'b0, "drain_2_busy");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_OFF,  1'b1, "halted_1");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_OFF,  1'b1, "halted_redirect");
    step(0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_OFF,  1'b1, "halted_hold");
    step(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "reset_from_halted");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "run_after_halt");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_HALT, 1'b0, "halt2");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_OFF,  1'b0, "drain_frozen_1");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_OFF,  1'b0, "drain_frozen_2");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_DRAIN,1'b0, "drain_ack");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN,1'b0, "drain_last");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_OFF,  1'b1, "halted_late");
    step(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "reset2");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "run2");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_HALT, 1'b0, "halt3");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN,1'b0, "drain_before_reset");
    step(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "reset_mid_drain");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "run_after_drain_reset");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "no_late_halt_1");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "no_late_halt_2");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_OFF,  1'b0, "mw_a");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_OFF,  1'b0, "mw_b");
    step(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "reset_mid_memwait");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "run_after_mw_reset");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RDR,  1'b0, "redirect_plain");
    step(0, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_LU,   1'b0, "lu_after_redirect");
    step(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, "final_idle");

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
